// File: rtl/ex_stage_v2.sv
// ex_stage_v2: execute stage with ALU, branch resolve, flush window, MDU link.
// EX_BARREL_SHIFT_EN selects single-cycle shifts over the iterative shifter.
module ex_stage_v2 #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [3:0]      ALU_CNT,
  input  logic [2:0]      FUN3,
  input  logic [XLEN-1:0] OP1,
  input  logic [XLEN-1:0] OP2,
  input  logic [XLEN-1:0] CMP1,
  input  logic [XLEN-1:0] CMP2,
  input  logic            CBRANCH,
  input  logic            JUMP,
  input  logic            JUMPR,
  input  logic [XLEN-1:0] JUMP_BASE,
  input  logic [XLEN-1:0] JUMP_OFF,
  input  logic [XLEN-1:0] PC_EX,
  input  logic [XLEN-1:0] PC_NEXT,
  input  logic            KILL,
  output logic            MDU_START,
  input  logic            MDU_READY,
  input  logic [XLEN-1:0] MDU_RESULT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] WB_DATA,
  output logic            JUMP_FINAL,
  output logic [XLEN-1:0] JUMP_ADDR,
  output logic            PREDICTED,
  output logic            FLUSH,
  output logic            EX_BUSY
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_MDU
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            out_valid_q;
  logic [XLEN-1:0] wb_q;
  logic            flush_q;
  logic [3:0]      fl_cnt;
  logic [XLEN-1:0] sh_val;
  logic [XLEN-1:0] sh_nxt;
  logic [SHW-1:0]  sh_cnt;
  logic [3:0]      sh_op;
  logic            accept;
  logic            live;
  logic            is_mdu;
  logic            iter;
  logic            cond;
  logic            taken;
  logic            mispred;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc_seq;

  assign shamt  = OP2[SHW-1:0];
  assign is_mdu = (ALU_CNT == 4'd15);
`ifdef EX_BARREL_SHIFT_EN
  assign iter   = 1'b0;
`else
  assign iter   = ((ALU_CNT == 4'd2) | (ALU_CNT == 4'd5) |
                   (ALU_CNT == 4'd6)) & (shamt != '0);
`endif

  assign IN_READY = (state == S_IDLE) & (!out_valid_q | OUT_READY) & !KILL;
  assign accept   = IN_VALID & IN_READY;
  assign live     = accept & !flush_q;
  assign pc_seq   = PC_EX + XLEN'(4);
  assign taken    = live & (JUMP | JUMPR | (CBRANCH & cond));
  assign mispred  = live & (taken ? (tgt != PC_NEXT) : (PC_NEXT != pc_seq));

  assign MDU_START  = live & is_mdu;
  assign JUMP_FINAL = taken & accept & !KILL;
  assign JUMP_ADDR  = tgt;
  assign PREDICTED  = !mispred;
  assign FLUSH      = flush_q;
  assign OUT_VALID  = out_valid_q;
  assign WB_DATA    = wb_q;
  assign EX_BUSY    = (state != S_IDLE);

  // single-cycle ALU result
  always_comb begin
    alu_res = '0;
    unique case (ALU_CNT)
      4'd0:  alu_res = OP1 + OP2;
      4'd1:  alu_res = OP1 - OP2;
`ifdef EX_BARREL_SHIFT_EN
      4'd2:  alu_res = OP1 << shamt;
      4'd5:  alu_res = OP1 >> shamt;
      4'd6:  alu_res = $signed(OP1) >>> shamt;
`else
      4'd2, 4'd5, 4'd6: alu_res = OP1;
`endif
      4'd3:  alu_res = XLEN'(OP1 < OP2);
      4'd4:  alu_res = OP1 ^ OP2;
      4'd7:  alu_res = OP1 | OP2;
      4'd8:  alu_res = OP1 & OP2;
      4'd9:  alu_res = OP1;
      4'd10: alu_res = OP2;
      4'd11: alu_res = XLEN'($signed(OP1) < $signed(OP2));
      4'd12: alu_res = OP2 + XLEN'(4);
      default: alu_res = '0;
    endcase
  end

  // branch condition
  always_comb begin
    cond = 1'b0;
    unique case (FUN3)
      3'b000: cond = (CMP1 == CMP2);
      3'b001: cond = (CMP1 != CMP2);
      3'b100: cond = ($signed(CMP1) < $signed(CMP2));
      3'b101: cond = ($signed(CMP1) >= $signed(CMP2));
      3'b110: cond = (CMP1 < CMP2);
      3'b111: cond = (CMP1 >= CMP2);
      default: cond = 1'b0;
    endcase
  end

  // redirect target, jalr drops bit 0
  always_comb begin
    tgt = JUMP_BASE + JUMP_OFF;
    if (JUMPR) tgt[0] = 1'b0;
  end

  // one-bit shift step of the iterative shifter
  always_comb begin
    sh_nxt = sh_val >> 1;
    if (sh_op == 4'd2) sh_nxt = sh_val << 1;
    if (sh_op == 4'd6) sh_nxt = {sh_val[XLEN-1], sh_val[XLEN-1:1]};
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (live & is_mdu)    state_nx = S_MDU;
        else if (live & iter) state_nx = S_SHIFT;
      end
      S_SHIFT: if (sh_cnt == SHW'(1)) state_nx = S_IDLE;
      S_MDU:   if (MDU_READY) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (KILL) state_nx = S_IDLE;
  end

  // result register, shifter operand and count
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      wb_q        <= '0;
      sh_val      <= '0;
      sh_cnt      <= '0;
      sh_op       <= '0;
    end else if (KILL) begin
      out_valid_q <= 1'b0;
    end else begin
      if (OUT_READY) out_valid_q <= 1'b0;
      if (live & !is_mdu & !iter) begin
        out_valid_q <= 1'b1;
        wb_q        <= alu_res;
      end
      if (live & iter) begin
        sh_val <= OP1;
        sh_cnt <= shamt;
        sh_op  <= ALU_CNT;
      end
      if (state == S_SHIFT) begin
        sh_val <= sh_nxt;
        sh_cnt <= sh_cnt - SHW'(1);
        if (sh_cnt == SHW'(1)) begin
          out_valid_q <= 1'b1;
          wb_q        <= sh_nxt;
        end
      end
      if ((state == S_MDU) & MDU_READY) begin
        out_valid_q <= 1'b1;
        wb_q        <= MDU_RESULT;
      end
    end
  end

  // wrong-path squash window
  always_ff @(posedge CLK) begin
    if (RST) begin
      flush_q <= 1'b0;
      fl_cnt  <= '0;
    end else if (mispred) begin
      flush_q <= 1'b1;
      fl_cnt  <= 4'(FLUSH_CYCLES - 1);
    end else if (flush_q) begin
      if (fl_cnt == 4'd0) flush_q <= 1'b0;
      else                fl_cnt  <= fl_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_ex_stage_v2.sv
// tb_ex_stage_v2: random ops against a reference model plus directed cases.
// Covers ALU, branches, flush window, MDU handshake, KILL, shifts, hold.
module tb_ex_stage_v2;
  localparam int XLEN = 32;
  localparam int FC   = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic            IN_VALID;
  logic            IN_READY;
  logic [3:0]      ALU_CNT;
  logic [2:0]      FUN3;
  logic [XLEN-1:0] OP1, OP2, CMP1, CMP2;
  logic            CBRANCH, JUMP, JUMPR;
  logic [XLEN-1:0] JUMP_BASE, JUMP_OFF, PC_EX, PC_NEXT;
  logic            KILL;
  logic            MDU_START;
  logic            MDU_READY;
  logic [XLEN-1:0] MDU_RESULT;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [XLEN-1:0] WB_DATA;
  logic            JUMP_FINAL;
  logic [XLEN-1:0] JUMP_ADDR;
  logic            PREDICTED;
  logic            FLUSH;
  logic            EX_BUSY;

  int checks = 0;
  int errors = 0;

  ex_stage_v2 #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_CNT(ALU_CNT), .FUN3(FUN3), .OP1(OP1), .OP2(OP2),
    .CMP1(CMP1), .CMP2(CMP2), .CBRANCH(CBRANCH), .JUMP(JUMP),
    .JUMPR(JUMPR), .JUMP_BASE(JUMP_BASE), .JUMP_OFF(JUMP_OFF),
    .PC_EX(PC_EX), .PC_NEXT(PC_NEXT), .KILL(KILL),
    .MDU_START(MDU_START), .MDU_READY(MDU_READY),
    .MDU_RESULT(MDU_RESULT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .WB_DATA(WB_DATA), .JUMP_FINAL(JUMP_FINAL),
    .JUMP_ADDR(JUMP_ADDR), .PREDICTED(PREDICTED), .FLUSH(FLUSH),
    .EX_BUSY(EX_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    IN_VALID = 0; ALU_CNT = 0; FUN3 = 0; OP1 = 0; OP2 = 0;
    CMP1 = 0; CMP2 = 0; CBRANCH = 0; JUMP = 0; JUMPR = 0;
    JUMP_BASE = 0; JUMP_OFF = 0; PC_EX = 32'h100; PC_NEXT = 32'h104;
    KILL = 0; MDU_READY = 0; MDU_RESULT = 0; OUT_READY = 1;
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0]  s;
    logic [31:0] ones;
    s = b[4:0];
    ones = '1;
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a << s;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: return a >> s;
      6: return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      7: return a | b;
      8: return a & b;
      9: return a;
      10: return b;
      11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      12: return b + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic cond_ref(input logic [2:0] f,
                                    input logic [31:0] x,
                                    input logic [31:0] y);
    case (f)
      3'b000: return x == y;
      3'b001: return x != y;
      3'b100: return $signed(x) < $signed(y);
      3'b101: return $signed(x) >= $signed(y);
      3'b110: return x < y;
      3'b111: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v[5];
    v = '{32'd0, 32'd1, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
    return v[$urandom_range(0, 4)];
  endfunction

  task automatic rand_op();
    logic [3:0]  op;
    logic [31:0] a, b, exp, tgt, pc;
    int          kind, lat, cyc, amt;
    logic        tk, mp;
    idle_in();
    op = 4'($urandom_range(0, 14));
    a = $urandom;
    b = $urandom;
    if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
    amt = int'(b[4:0]);
    kind = $urandom_range(0, 3);
    FUN3 = 3'($urandom_range(0, 7));
    CMP1 = pick();
    CMP2 = pick();
    CBRANCH = (kind == 1);
    JUMP = (kind == 2);
    JUMPR = (kind == 3);
    JUMP_BASE = $urandom;
    JUMP_OFF = 32'($urandom_range(0, 255));
    pc = $urandom & ~32'd3;
    tgt = JUMP_BASE + JUMP_OFF;
    if (JUMPR) tgt = tgt & ~32'd1;
    case ($urandom_range(0, 2))
      0: PC_NEXT = pc + 32'd4;
      1: PC_NEXT = tgt;
      default: PC_NEXT = $urandom;
    endcase
    PC_EX = pc;
    tk = JUMP | JUMPR | (CBRANCH & cond_ref(FUN3, CMP1, CMP2));
    mp = tk ? (tgt != PC_NEXT) : (PC_NEXT != pc + 32'd4);
    exp = alu_ref(op, a, b);
    ALU_CNT = op; OP1 = a; OP2 = b; IN_VALID = 1;
`ifdef EX_BARREL_SHIFT_EN
    lat = 1;
`else
    lat = ((op == 2 || op == 5 || op == 6) && amt != 0) ? amt + 1 : 1;
`endif
    #3;
    chk("r_ready", 32'(IN_READY), 32'd1);
    chk("r_jfinal", 32'(JUMP_FINAL), 32'(tk));
    chk("r_pred", 32'(PREDICTED), 32'(!mp));
    if (tk) chk("r_jaddr", JUMP_ADDR, tgt);
    tick();
    IN_VALID = 0;
    chk("r_flush", 32'(FLUSH), 32'(mp));
    cyc = 1;
    while (!OUT_VALID && cyc < 60) begin
      tick();
      cyc++;
    end
    chk("r_lat", 32'(cyc), 32'(lat));
    chk("r_wb", WB_DATA, exp);
    tick();
    for (int k = 0; k < 20 && FLUSH; k++) tick();
    chk("r_flush_end", 32'(FLUSH), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int bad, fl, cyc;
    logic [31:0] held;
    idle_in();
    RST = 1;
    repeat (3) tick();
    RST = 0;
    #3;
    chk("rst_ov", 32'(OUT_VALID), 32'd0);
    chk("rst_wb", WB_DATA, 32'd0);
    chk("rst_flush", 32'(FLUSH), 32'd0);
    chk("rst_busy", 32'(EX_BUSY), 32'd0);
    chk("rst_ready", 32'(IN_READY), 32'd1);
    chk("rst_pred", 32'(PREDICTED), 32'd1);
    chk("rst_mstart", 32'(MDU_START), 32'd0);
    tick();

    ALU_CNT = 0; OP1 = 32'hFFFF_FFFF; OP2 = 1; IN_VALID = 1;
    tick();
    chk("add_ov", 32'(OUT_VALID), 32'd1);
    chk("add_wb", WB_DATA, 32'd0);
    ALU_CNT = 10; OP2 = 32'hCAFE_0123;
    tick();
    IN_VALID = 0;
    chk("pass2_wb", WB_DATA, 32'hCAFE_0123);
    tick();
    chk("ov_drop", 32'(OUT_VALID), 32'd0);

    idle_in();
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1; ALU_CNT = 0; OP1 = 32'(i * 16); OP2 = 7;
      tick();
      chk("b2b_ov", 32'(OUT_VALID), 32'd1);
      chk("b2b_wb", WB_DATA, 32'(i * 16 + 7));
    end
    idle_in();
    tick();

    CBRANCH = 1; FUN3 = 3'b000; CMP1 = 5; CMP2 = 5;
    JUMP_BASE = 32'hF0; JUMP_OFF = 32'h10;
    PC_EX = 32'h40; PC_NEXT = 32'h44; IN_VALID = 1;
    #3;
    chk("beq_jf", 32'(JUMP_FINAL), 32'd1);
    chk("beq_addr", JUMP_ADDR, 32'h100);
    chk("beq_pred", 32'(PREDICTED), 32'd0);
    tick();
    idle_in();
    fl = 0;
    bad = 0;
    for (int i = 1; i <= 8; i++) begin
      if (FLUSH) fl++;
      if (i >= 2 && i <= 4 && OUT_VALID) bad++;
      if (i <= 3) begin
        IN_VALID = 1; JUMP = 1; JUMP_BASE = 32'h800;
        ALU_CNT = (i == 2) ? 4'd15 : 4'd0;
        #3;
        if (!IN_READY || JUMP_FINAL || MDU_START || !PREDICTED) bad++;
      end
      tick();
      idle_in();
    end
    chk("beq_flush_len", 32'(fl), 32'(FC));
    chk("beq_squash", 32'(bad), 32'd0);
    chk("beq_busy", 32'(EX_BUSY), 32'd0);

    FUN3 = 3'b110; CBRANCH = 1; CMP1 = 32'hFFFF_FFFF; CMP2 = 1;
    JUMP_BASE = 32'h500; IN_VALID = 1;
    #3;
    chk("bltu_jf", 32'(JUMP_FINAL), 32'd0);
    chk("bltu_pred", 32'(PREDICTED), 32'd1);
    tick();
    idle_in();
    chk("bltu_flush", 32'(FLUSH), 32'd0);
    tick();

    ALU_CNT = 15; IN_VALID = 1;
    #3;
    chk("mdu_start", 32'(MDU_START), 32'd1);
    tick();
    IN_VALID = 0;
    bad = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) begin
        MDU_READY = 1;
        MDU_RESULT = 32'h1234;
      end
      #3;
      if (IN_READY !== 1'b0 || MDU_START !== 1'b0 || EX_BUSY !== 1'b1) bad++;
      tick();
    end
    MDU_READY = 0;
    chk("mdu_wait", 32'(bad), 32'd0);
    chk("mdu_ov", 32'(OUT_VALID), 32'd1);
    chk("mdu_wb", WB_DATA, 32'h1234);
    chk("mdu_idle", 32'(EX_BUSY), 32'd0);
    tick();

    ALU_CNT = 15; IN_VALID = 1;
    tick();
    IN_VALID = 0;
    tick();
    KILL = 1; MDU_READY = 1; MDU_RESULT = 32'hDEAD;
    IN_VALID = 1; ALU_CNT = 0;
    #3;
    chk("kill_ready", 32'(IN_READY), 32'd0);
    tick();
    idle_in();
    chk("kill_ov", 32'(OUT_VALID), 32'd0);
    chk("kill_busy", 32'(EX_BUSY), 32'd0);
    tick();
    chk("kill_ov2", 32'(OUT_VALID), 32'd0);

    ALU_CNT = 6; OP1 = 32'h8000_0000; OP2 = 4; IN_VALID = 1;
    tick();
    IN_VALID = 0;
    OUT_READY = 0;
    cyc = 1;
    while (!OUT_VALID && cyc < 40) begin
      tick();
      cyc++;
    end
`ifdef EX_BARREL_SHIFT_EN
    chk("sra_lat", 32'(cyc), 32'd1);
`else
    chk("sra_lat", 32'(cyc), 32'd5);
`endif
    chk("sra_wb", WB_DATA, 32'hF800_0000);
    held = 32'hF800_0000;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      #3;
      if (!OUT_VALID || WB_DATA !== held || IN_READY) bad++;
    end
    chk("hold", 32'(bad), 32'd0);
    OUT_READY = 1;
    #1;
    chk("hold_rel_ready", 32'(IN_READY), 32'd1);
    tick();
    chk("hold_rel_ov", 32'(OUT_VALID), 32'd0);

    ALU_CNT = 15; JUMP = 1; JUMP_BASE = 32'h900; IN_VALID = 1;
    tick();
    idle_in();
    chk("rstmid_flush_pre", 32'(FLUSH), 32'd1);
    RST = 1;
    tick();
    RST = 0;
    chk("rstmid_flush", 32'(FLUSH), 32'd0);
    chk("rstmid_busy", 32'(EX_BUSY), 32'd0);
    tick();

    for (int n = 0; n < 40; n++) rand_op();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage_v2.md
# ex_stage_v2

Parametrised second-generation execute stage for the RISC-V pipeline. It sits between decode/operand-fetch and the data-cache stage. It covers ALU evaluation, branch/jump resolution against the fetched next PC, and the flush-window sequencing that squashes wrong-path instructions. Unlike the first generation it has:

- a registered valid/ready output,
- a START/READY handshake to an external multiply/divide unit,
- configurable data width and flush length,
- an optional iterative (area-saving) shifter.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 and 64. SHW = log2(XLEN).
- FLUSH_CYCLES, 4: cycles FLUSH stays high after a redirect; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- IN_VALID  in  1  operation offered.
- IN_READY  out  1  operation accepted this cycle when IN_VALID & IN_READY.
- ALU_CNT  in  4  operation code:
  - 0 add, 1 sub, 2 sll, 3 sltu, 4 xor, 5 srl, 6 sra, 7 or
  - 8 and, 9 pass OP1, 10 pass OP2, 11 slt, 12 OP2+4, 13 idle (zero), 14 reserved (zero), 15 mdu
- FUN3  in  3  branch condition: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu; 010/011 never taken.
- OP1, OP2  in  XLEN  ALU operands.
- CMP1, CMP2  in  XLEN  branch comparands.
- CBRANCH, JUMP, JUMPR  in  1  conditional branch, jal, jalr.
- JUMP_BASE, JUMP_OFF  in  XLEN  target = JUMP_BASE + JUMP_OFF (jalr: bit 0 cleared).
- PC_EX  in  XLEN  PC of the offered operation.
- PC_NEXT  in  XLEN  PC the front end fetched after PC_EX.
- KILL  in  1  trap/abort from the privileged unit.
- MDU_START  out  1  one-cycle start pulse to the multiply/divide unit.
- MDU_READY  in  1  MDU result valid.
- MDU_RESULT  in  XLEN  MDU result.
- OUT_VALID  out  1  registered result valid.
- OUT_READY  in  1  downstream consumes the result.
- WB_DATA  out  XLEN  registered result.
- JUMP_FINAL  out  1  taken redirect; combinational, in the accept cycle.
- JUMP_ADDR  out  XLEN  redirect target; combinational.
- PREDICTED  out  1  front end predicted correctly (1 when not accepting).
- FLUSH  out  1  wrong-path squash window.
- EX_BUSY  out  1  multi-cycle operation in progress.

## Operation
- **States:** IDLE, SHIFT, MDU_WAIT.
- **IN_READY:** `(state==IDLE) & (!OUT_VALID | OUT_READY) & !KILL`.
- **Accept in IDLE:**
  - Single-cycle ops load WB_DATA and set OUT_VALID on the next edge.
  - ALU_CNT=15: MDU_START=1 in the accept cycle, then go to MDU_WAIT. On MDU_READY, load MDU_RESULT, set OUT_VALID, return to IDLE.
- **Arithmetic:**
  - Modulo 2^XLEN, carries discarded.
  - Shift amount is OP2[SHW-1:0].
  - slt is signed, sltu is unsigned.
  - Branch compares are signed for blt/bge and unsigned for bltu/bgeu.
- **taken:** `(JUMP | JUMPR | (CBRANCH & cond))` for an accepted op with FLUSH=0.
- **mispredict:**
  - If taken: JUMP_ADDR != PC_NEXT.
  - If not taken: PC_NEXT != PC_EX+4.
  - PREDICTED = !mispredict during accept; 1 otherwise.
- **JUMP_FINAL:** = taken & accept & !KILL.
- **Flush window:**
  - A mispredict on accept sets FLUSH on the next edge and loads a counter with FLUSH_CYCLES-1.
  - FLUSH is held until the counter reaches 0, i.e. exactly FLUSH_CYCLES cycles high.
  - While FLUSH=1, offered ops are still accepted (IN_READY obeys the rule above) but squashed: no OUT_VALID, no MDU_START, no JUMP_FINAL, no new mispredict.
- **KILL:**
  - Clears OUT_VALID and returns to IDLE on the next edge.
  - An in-flight MDU result is discarded; a MDU_READY in the same cycle is ignored.
  - KILL together with IN_VALID accepts nothing.
  - KILL does not touch FLUSH.
- **Output hold:** OUT_VALID & !OUT_READY holds WB_DATA and OUT_VALID stable.

## Timing
- **Reset values:** state=IDLE, OUT_VALID=0, WB_DATA=0, FLUSH=0, flush counter=0, shift counter=0, MDU_START=0, EX_BUSY=0. Combinational outputs follow from these.
- **Reset mid-operation:** aborts SHIFT/MDU_WAIT identically to KILL; RST also clears FLUSH.
- **Single-cycle op:** result at edge+1 (latency 1).
- **MDU op:** result on the edge after MDU_READY; minimum latency 2.
- **Back-to-back:** single-cycle ops reach throughput 1/cycle while OUT_READY=1.
- **EX_BUSY:** = state != IDLE.

## Configuration
- **EX_BARREL_SHIFT_EN defined:** sll/srl/sra are single-cycle barrel shifts; the SHIFT state is unreachable.
- **EX_BARREL_SHIFT_EN undefined:**
  - A shift with amount 0 completes in one cycle.
  - Otherwise the operand is latched, the block enters SHIFT, and it shifts 1 bit per cycle (sra replicates the MSB) using a counter loaded with the amount.
  - OUT_VALID appears amount+1 cycles after accept. IN_READY=0 meanwhile.
  - Branch/jump resolution of the shift op itself still happens in the accept cycle.

## Test plan
- **add, XLEN=32:** OP1=0xFFFFFFFF, OP2=1 -> WB_DATA=0 with OUT_VALID one cycle later; OP2 is passed through unchanged for pass-OP2.
- **beq, equal comparands, mispredicted:** CMP1=CMP2=5, target=0x100, PC_NEXT=PC_EX+4 -> JUMP_FINAL=1, JUMP_ADDR=0x100, PREDICTED=0; FLUSH high exactly 4 cycles; 3 ops offered during the window yield no OUT_VALID.
- **bltu, not taken, predicted:** CMP1=0xFFFFFFFF, CMP2=1, PC_NEXT=PC_EX+4 -> JUMP_FINAL=0, PREDICTED=1, FLUSH stays 0.
- **MDU handshake:** accept ALU_CNT=15 -> MDU_START for 1 cycle; MDU_READY 6 cycles later with 0x1234 -> WB_DATA=0x1234; IN_READY=0 throughout the wait.
- **KILL during MDU_WAIT:** assert KILL in the same cycle as MDU_READY -> OUT_VALID stays 0 and state returns to IDLE.
- **sra without EX_BARREL_SHIFT_EN:** OP1=0x80000000, OP2=4 -> 0xF8000000 after 5 cycles; with the macro defined, the same result after 1 cycle. Backpressure: OUT_READY=0 holds WB_DATA.
